fu_mul_sequencer: RTL and testbench

//  Multi-cycle 32x32 unsigned multiplier (low 32-bit product) built on the shared FunctionUnit.

---
 rtl/fu_mul_sequencer_pkg.sv | 17 +
 rtl/fu_mul_sequencer.sv | 134 +++++++++++++
 tb/tb_fu_mul_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: FunctionUnit opcodes and FSM states.
package fu_mul_sequencer_pkg;

  localparam logic [3:0] FS_ADD = 4'b0010;
  localparam logic [3:0] FS_SHL = 4'b1110;
  localparam logic [3:0] FS_SHR = 4'b1101;
  localparam logic [3:0] FS_NOP = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SHL  = 3'd2,
    ST_SHR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/fu_mul_sequencer.sv
// Multi-cycle 32x32 unsigned multiply (low word) driving the shared FunctionUnit one op per cycle.
// Handshake: start is sampled only in IDLE; done pulses for one cycle with result/overflow already valid.
module fu_mul_sequencer
  import fu_mul_sequencer_pkg::*;
#(
  parameter int W          = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic [3:0]   fu_fs,
  output logic [4:0]   fu_sh,
  output logic [W-1:0] fu_a,
  output logic [W-1:0] fu_b,
  input  logic [W-1:0] fu_fout,
  input  logic         fu_carryout,
  input  logic         fu_zero,
  output state_t       dbg_state
);

  localparam logic [5:0] LAST_ITER = 6'(W - 1);

  state_t         state;
  logic [W-1:0]   acc;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [5:0]     cnt;
  logic           ovf;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    fu_fs = FS_NOP;
    fu_sh = 5'd0;
    fu_a  = '0;
    fu_b  = '0;
    case (state)
      ST_ADD: begin
        fu_fs = FS_ADD;
        fu_a  = acc;
        fu_b  = mcand;
      end
      ST_SHL: begin
        fu_fs = FS_SHL;
        fu_sh = 5'd1;
        fu_a  = mcand;
      end
      ST_SHR: begin
        fu_fs = FS_SHR;
        fu_sh = 5'd1;
        fu_a  = mplier;
      end
      default: ;
    endcase
  end

  // result/overflow/done are loaded on the transition into DONE so they are valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= 6'd0;
      ovf      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a_in;
            mplier <= b_in;
            ovf    <= 1'b0;
            cnt    <= 6'd0;
            if (EARLY_EXIT && (b_in == '0)) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              result   <= '0;
              overflow <= 1'b0;
            end else if (b_in[0]) begin
              state <= ST_ADD;
            end else begin
              state <= ST_SHL;
            end
          end
        end
        ST_ADD: begin
          acc   <= fu_fout;
          ovf   <= ovf | fu_carryout;
          state <= ST_SHL;
        end
        ST_SHL: begin
          // A bit shifted out of the multiplicand is lost product only if a later multiplier bit is set.
          mcand <= fu_fout;
          ovf   <= ovf | (mcand[W-1] & (mplier[W-1:1] != '0));
          state <= ST_SHR;
        end
        ST_SHR: begin
          mplier <= fu_fout;
          cnt    <= cnt + 6'd1;
          if ((EARLY_EXIT && fu_zero) || (cnt == LAST_ITER)) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            result   <= acc;
            overflow <= ovf;
          end else if (fu_fout[0]) begin
            state <= ST_ADD;
          end else begin
            state <= ST_SHL;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// Bench: two sequencers (early exit on/off), each wired to a behavioural FunctionUnit, checked against a*b.
module tb_fu_mul_sequencer;
  import fu_mul_sequencer_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;

  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [31:0] res0, res1;
  logic [3:0]  fs0, fs1;
  logic [4:0]  sh0, sh1;
  logic [31:0] fa0, fb0, fa1, fb1, fout0, fout1;
  logic        carry0, zero0, carry1, zero1;
  state_t      dbg0, dbg1;

  int vectors = 0;
  int miscompares = 0;

  fu_mul_sequencer #(.W(32), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .start(start0), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .result(res0), .overflow(ovf0),
    .fu_fs(fs0), .fu_sh(sh0), .fu_a(fa0), .fu_b(fb0),
    .fu_fout(fout0), .fu_carryout(carry0), .fu_zero(zero0), .dbg_state(dbg0)
  );

  fu_mul_sequencer #(.W(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .result(res1), .overflow(ovf1),
    .fu_fs(fs1), .fu_sh(sh1), .fu_a(fa1), .fu_b(fb1),
    .fu_fout(fout1), .fu_carryout(carry1), .fu_zero(zero1), .dbg_state(dbg1)
  );

  // Behavioural FunctionUnit: returns {zero, carry, fout}.
  function automatic logic [33:0] fu_eval(input logic [3:0] fs, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] f;
    logic        c;
    sum = {1'b0, a} + {1'b0, b};
    f   = '0;
    c   = 1'b0;
    case (fs)
      FS_ADD: begin f = sum[31:0]; c = sum[32]; end
      FS_SHL: f = a << sh;
      FS_SHR: f = a >> sh;
      default: f = '0;
    endcase
    return {(f == '0), c, f};
  endfunction

  always_comb {zero0, carry0, fout0} = fu_eval(fs0, sh0, fa0, fb0);
  always_comb {zero1, carry1, fout1} = fu_eval(fs1, sh1, fa1, fb1);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver + scoreboard for one multiply on both instances.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit pulse);
    logic [63:0] prod;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    int          msb, lat0_exp, lat1_exp, lat0, lat1;
    prod = 64'(a) * 64'(b);
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    lat0_exp = 1;
    for (int i = 0; i <= msb; i++) begin
      if (b[i]) begin
        exp_q.push_back(FS_ADD);
        lat0_exp += 1;
      end
      exp_q.push_back(FS_SHL);
      exp_q.push_back(FS_SHR);
      lat0_exp += 2;
    end
    lat1_exp = 65 + $countones(b);

    @(negedge clk);
    a_in = a; b_in = b; start0 = 1'b1; start1 = 1'b1;
    lat0 = 0; lat1 = 0;
    for (int cyc = 1; cyc <= 200 && (lat0 == 0 || lat1 == 0); cyc++) begin
      @(negedge clk);
      if (pulse) begin
        a_in = $urandom;
        b_in = $urandom;
      end
      if (lat0 == 0) begin
        if (done0) begin
          lat0 = cyc;
          check_eq("ee_result", 64'(res0), 64'(prod[31:0]));
          check_eq("ee_overflow", 64'(ovf0), 64'(prod[63:32] != 0));
          check_eq("ee_fs_in_done", 64'(fs0), 64'(FS_NOP));
          check_eq("ee_busy_in_done", 64'(busy0), 64'd1);
          start0 = 1'b0;
        end else begin
          got_q.push_back(fs0);
          start0 = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end else begin
        if (cyc == lat0 + 1) begin
          check_eq("ee_done_one_cycle", 64'(done0), 64'd0);
          check_eq("ee_idle_after_done", 64'(busy0), 64'd0);
        end
        start0 = 1'b0;
      end
      if (lat1 == 0) begin
        if (done1) begin
          lat1 = cyc;
          check_eq("full_result", 64'(res1), 64'(prod[31:0]));
          check_eq("full_overflow", 64'(ovf1), 64'(prod[63:32] != 0));
          start1 = 1'b0;
        end else begin
          start1 = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
    start0 = 1'b0; start1 = 1'b0;
    check_eq("ee_latency", 64'(lat0), 64'(lat0_exp));
    check_eq("full_latency", 64'(lat1), 64'(lat1_exp));
    check_eq("ee_op_count", 64'(got_q.size()), 64'(exp_q.size()));
    if (got_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check_eq($sformatf("ee_op[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
    repeat (2) @(negedge clk);
    check_eq("idle_done", 64'({done0, done1, busy0, busy1}), 64'd0);
    check_eq("ee_result_held", 64'({ovf0, res0}), {31'd0, prod[63:32] != 0, prod[31:0]});
    check_eq("full_result_held", 64'({ovf1, res1}), {31'd0, prod[63:32] != 0, prod[31:0]});
  endtask

  task automatic reset_mid_op();
    int spurious;
    @(negedge clk);
    a_in = 32'h0000_1234; b_in = 32'h0000_00FF; start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", 64'({busy0, busy1}), 64'd0);
    check_eq("rst_done", 64'({done0, done1}), 64'd0);
    check_eq("rst_result", 64'({ovf0, res0}), 64'd0);
    check_eq("rst_result_full", 64'({ovf1, res1}), 64'd0);
    check_eq("rst_state", 64'(dbg0), 64'(ST_IDLE));
    spurious = 0;
    repeat (120) begin
      @(negedge clk);
      if (done0 || done1 || busy0 || busy1) spurious++;
    end
    check_eq("rst_no_done", 64'(spurious), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_state", 64'(dbg0), 64'(ST_IDLE));
    check_eq("reset_outputs", 64'({busy0, done0, ovf0, res0}), 64'd0);
    check_eq("reset_fu_idle", 64'({fs0, sh0, fa0, fb0}), {25'd0, 4'hF, 5'd0, 64'd0});
    rst = 1'b0;
    @(negedge clk);

    run_mul(32'd3, 32'd5, 1'b0);
    run_mul(32'd7, 32'd0, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
    run_mul(32'h0001_0000, 32'h0001_0000, 1'b0);
    run_mul(32'h8000_0001, 32'd3, 1'b0);
    run_mul(32'd1, 32'hFFFF_FFFF, 1'b1);
    reset_mid_op();
    run_mul(32'd11, 32'd13, 1'b0);

    for (int n = 0; n < 30; n++)
      run_mul($urandom, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
